// File: rtl/pea_pkg.sv
// Shared PE-array definitions: datapath width and divider issue-control types.
package pea_pkg;
  localparam int N_BITS = 32;
  localparam int DIV_TIMEOUT_DEFAULT = 2*N_BITS+4;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;
endpackage

// File: rtl/div_special_detect.sv
// Flags operand pairs the divider must never see and supplies their fixed results.
module div_special_detect #(
  parameter int N_BITS = pea_pkg::N_BITS
) (
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic              is_div0,
  output logic              is_ovf,
  output logic [N_BITS-1:0] sp_q,
  output logic [N_BITS-1:0] sp_r
);
  localparam logic [N_BITS-1:0] MOST_NEG = {1'b1, {(N_BITS-1){1'b0}}};

  assign is_div0 = (b == '0);
  assign is_ovf  = (a == MOST_NEG) && (b == '1);
  // Divide-by-zero: q = -1, r = a.  Overflow: q = most-negative, r = 0.
  assign sp_q    = is_div0 ? '1 : MOST_NEG;
  assign sp_r    = is_div0 ? a  : '0;
endmodule

// File: rtl/div_issue_ctrl.sv
// Issue control for the PE divider: accepts one op, screens special cases,
// runs the divider under a watchdog and holds the result until consumed.
module div_issue_ctrl #(
  parameter int N_BITS         = pea_pkg::N_BITS,
  parameter int TIMEOUT_CYCLES = 2*N_BITS+4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  input  logic              op_rem_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [N_BITS-1:0] div_a_o,
  output logic [N_BITS-1:0] div_b_o,
  output logic              div_en_o,
  input  logic [N_BITS-1:0] div_q_i,
  input  logic [N_BITS-1:0] div_r_i,
  input  logic              div_valid_i,
  output logic [N_BITS-1:0] res_o,
  output logic              res_err_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              busy_o
);
  import pea_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES-1);

  div_state_e        state, state_d;
  logic [N_BITS-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic              op_q, op_d, err_q, err_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              launch;

  logic              is_div0, is_ovf;
  logic [N_BITS-1:0] sp_q, sp_r;

  div_special_detect #(.N_BITS(N_BITS)) u_special (
    .a       (a_i),
    .b       (b_i),
    .is_div0 (is_div0),
    .is_ovf  (is_ovf),
    .sp_q    (sp_q),
    .sp_r    (sp_r)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= DIV_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= 1'b0;
      res_q <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      res_q <= res_d;
      err_q <= err_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt;
    launch  = 1'b0;
    case (state)
      DIV_IDLE: launch = in_valid_i;
      DIV_RUN: begin
        cnt_d = cnt + CNT_W'(1);
        // A result arriving in the watchdog's final cycle still counts as good.
        if (div_valid_i) begin
          res_d   = op_q ? div_r_i : div_q_i;
          err_d   = 1'b0;
          state_d = DIV_DONE;
        end else if (cnt == CNT_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (res_ready_i) begin
          state_d = DIV_IDLE;
          launch  = in_valid_i;
        end
      end
      default: state_d = DIV_IDLE;
    endcase

    if (launch) begin
      a_d   = a_i;
      b_d   = b_i;
      op_d  = op_rem_i;
      cnt_d = '0;
      if (is_div0 || is_ovf) begin
        res_d   = op_rem_i ? sp_r : sp_q;
        err_d   = 1'b0;
        state_d = DIV_DONE;
      end else begin
        state_d = DIV_RUN;
      end
    end
  end

  // Ready depends only on state and the consumer, never on in_valid_i.
  assign in_ready_o  = (state == DIV_IDLE) || ((state == DIV_DONE) && res_ready_i);
  assign div_en_o    = (state == DIV_RUN);
  assign res_valid_o = (state == DIV_DONE);
  assign busy_o      = (state != DIV_IDLE);
  assign div_a_o     = a_q;
  assign div_b_o     = b_q;
  assign res_o       = res_q;
  assign res_err_o   = err_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural divider of programmable latency.
module tb_div_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_i, b_i, div_a_o, div_b_o, div_q_i, div_r_i, res_o;
  logic        op_rem_i, in_valid_i, in_ready_o, div_en_o, div_valid_i;
  logic        res_err_o, res_valid_o, res_ready_i, busy_o;

  div_issue_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .a_i(a_i), .b_i(b_i), .op_rem_i(op_rem_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .div_a_o(div_a_o),
    .div_b_o(div_b_o), .div_en_o(div_en_o), .div_q_i(div_q_i), .div_r_i(div_r_i),
    .div_valid_i(div_valid_i), .res_o(res_o), .res_err_o(res_err_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] res; logic err; } exp_t;
  exp_t        sb[$];
  int          n_tests = 0, n_fail = 0;
  int          div_lat = 0;
  int          en_total = 0, stab_total = 0, cyc = 0, t_acc = 0;
  logic [31:0] cur_a = '0, cur_b = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Divider model: answers div_lat cycles into RUN; div_lat==0 means never.
  initial begin
    int run_cnt;
    run_cnt = 0;
    div_valid_i = 1'b0; div_q_i = '0; div_r_i = '0;
    forever begin
      @(posedge clk); #1;
      run_cnt     = div_en_o ? run_cnt + 1 : 0;
      div_valid_i = div_en_o && (div_lat > 0) && (run_cnt == div_lat);
      if (div_en_o && div_b_o != 0) begin
        div_q_i = $signed(div_a_o) / $signed(div_b_o);
        div_r_i = $signed(div_a_o) % $signed(div_b_o);
      end
    end
  end

  // Monitor: tracks divider activity and pops the scoreboard on each result handshake.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (div_en_o) begin
      en_total++;
      if (div_a_o !== cur_a || div_b_o !== cur_b) stab_total++;
    end
    if (rst_n && res_valid_o && res_ready_i) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("res", res_o, e.res);
        chk("res_err", res_err_o, e.err);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [31:0] er, input logic ee);
    bit done = 0;
    a_i = a; b_i = b; op_rem_i = op; in_valid_i = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready_o) begin
        sb.push_back('{er, ee});
        cur_a = a; cur_b = b;
        done = 1;
      end
      @(posedge clk); #1;
      if (done) t_acc = cyc;
    end
    in_valid_i = 1'b0;
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_result(input string nm, input int exp_lat);
    int n = 0;
    bit seen = 0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      if (res_valid_o) seen = 1;
    end
    chk({nm, "_lat"}, n, exp_lat);
  endtask

  initial begin
    int e0, s0, t1;
    rst_n = 1'b0; a_i = '0; b_i = '0; op_rem_i = 1'b0; in_valid_i = 1'b0; res_ready_i = 1'b1;
    @(negedge clk);
    chk("rst_flags", {in_ready_o, div_en_o, res_valid_o, busy_o, res_err_o}, 5'b10000);
    chk("rst_res", res_o, 32'h0);
    chk("rst_div_ops", {div_a_o, div_b_o}, 64'h0);
    step(); rst_n = 1'b1; step();

    div_lat = 34; e0 = en_total;
    issue(100, 7, 0, 32'd14, 0);
    wait_result("q_100_7", 35);
    chk("q_100_7_en", en_total - e0, 34);
    step();

    div_lat = 5; s0 = stab_total;
    issue(-100, 7, 1, 32'hFFFFFFFE, 0);
    wait_result("r_m100_7", 6);
    chk("operand_stable", stab_total - s0, 0);
    step();

    e0 = en_total;
    issue(55, 0, 0, 32'hFFFFFFFF, 0);
    wait_result("div0_q", 1);
    step();
    issue(55, 0, 1, 32'd55, 0);
    wait_result("div0_r", 1);
    step();
    issue(32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0);
    wait_result("ovf_q", 1);
    step();
    issue(32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 0);
    wait_result("ovf_r", 1);
    chk("special_no_en", en_total - e0, 0);
    step();

    div_lat = 0;
    issue(12, 5, 0, 32'h0, 1);
    wait_result("timeout", 69);
    step();

    div_lat = 68;
    issue(1000, -3, 0, 32'hFFFFFEB3, 0);
    wait_result("valid_at_timeout", 69);
    step();

    issue(55, 0, 1, 32'd55, 0);
    t1 = t_acc;
    issue(7, 0, 0, 32'hFFFFFFFF, 0);
    chk("b2b_accept_cycle", t_acc, t1 + 1);
    wait_result("b2b", 1);
    step();

    res_ready_i = 1'b0;
    issue(55, 0, 0, 32'hFFFFFFFF, 0);
    a_i = 9; b_i = 3; in_valid_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_res", {res_valid_o, res_err_o, res_o}, {2'b10, 32'hFFFFFFFF});
      chk("hold_in_ready", in_ready_o, 0);
    end
    step(); in_valid_i = 1'b0; res_ready_i = 1'b1;
    step(); step();

    div_lat = 0;
    issue(100, 7, 0, 32'd14, 0);
    repeat (10) step();
    chk("mid_run_busy", {busy_o, div_en_o}, 2'b11);
    rst_n = 1'b0; #1;
    chk("arst_flags", {in_ready_o, div_en_o, res_valid_o, busy_o, res_err_o}, 5'b10000);
    chk("arst_res", res_o, 32'h0);
    chk("arst_div_ops", {div_a_o, div_b_o}, 64'h0);
    sb.delete();
    step(); rst_n = 1'b1; step();

    div_lat = 3;
    issue(-7, 2, 0, 32'hFFFFFFFD, 0);
    wait_result("after_reset", 4);
    step(); step();

    chk("sb_empty", sb.size(), 0);
    chk("stable_total", stab_total, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
